// File: rtl/serial_frame_decoder_pkg.sv
// Shared constants and encodings for the serial command frame decoder.
// Frame layout: FF FF 00 LEN PAYLOAD[LEN] EE EE.
package serial_frame_decoder_pkg;

  localparam logic [7:0] SOF_BYTE   = 8'hFF;
  localparam logic [7:0] EOF_BYTE   = 8'hEE;
  localparam logic [7:0] SPACE_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_SPACE = 3'd1,
    ERR_BAD_LEN   = 3'd2,
    ERR_BAD_EOF   = 3'd3,
    ERR_LINE      = 3'd4,
    ERR_TIMEOUT   = 3'd5,
    ERR_OVERRUN   = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF2,
    ST_SPACE,
    ST_LEN,
    ST_PAYLOAD,
    ST_EOF1,
    ST_EOF2,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/serial_frame_buffer.sv
// Payload store: register array, one write port and a registered
// read port returning zero beyond the frame length.
module serial_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_len,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] addr_ext;

  assign addr_ext = 8'(rd_addr);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (addr_ext < rd_len) rd_data <= mem[rd_addr];
    else rd_data <= 8'h00;
  end

endmodule

// File: rtl/serial_frame_decoder.sv
// Byte-level command frame parser between UART receiver and executor.
// Buffers one frame and holds it until the executor acks it.
module serial_frame_decoder
  import serial_frame_decoder_pkg::*;
#(
  parameter int MAX_PAYLOAD_LEN    = 16,
  parameter int BYTE_TIMEOUT_TICKS = 50000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [7:0]                         byte_data,
  input  logic                               byte_valid,
  input  logic                               byte_err,
  output logic                               frame_valid,
  input  logic                               frame_ack,
  output logic [7:0]                         payload_len,
  input  logic [$clog2(MAX_PAYLOAD_LEN)-1:0] rd_addr,
  output logic [7:0]                         rd_data,
  output logic                               busy,
  output logic                               frame_error,
  output logic [2:0]                         error_code
);

  localparam int AW = $clog2(MAX_PAYLOAD_LEN);
  localparam int CW = $clog2(BYTE_TIMEOUT_TICKS + 1);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD_LEN);
  localparam logic [CW-1:0] TO_LAST = CW'(BYTE_TIMEOUT_TICKS - 1);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ferr_q;
  err_e          code_q;
  err_e          err_cause;
  logic          err_set;
  logic          wr_en;
  logic          in_frame;
  logic          timeout;

  assign in_frame = (state_q != ST_IDLE) && (state_q != ST_HOLD);
  assign timeout  = in_frame && !byte_valid && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    err_cause = ERR_NONE;
    cnt_d     = (in_frame && !byte_valid) ? cnt_q + 1'b1 : '0;
    if (state_q == ST_HOLD) begin
      // the held frame survives an overrun; only the ack frees it
      if (byte_valid) begin
        err_set   = 1'b1;
        err_cause = ERR_OVERRUN;
      end
      if (frame_ack) state_d = ST_IDLE;
    end else if (byte_valid && state_q == ST_IDLE) begin
      if (!byte_err && byte_data == SOF_BYTE) state_d = ST_SOF2;
    end else if (byte_valid && byte_err) begin
      err_set   = 1'b1;
      err_cause = ERR_LINE;
    end else if (byte_valid) begin
      unique case (state_q)
        ST_SOF2: begin
          state_d = (byte_data == SOF_BYTE) ? ST_SPACE : ST_IDLE;
        end
        ST_SPACE: begin
          if (byte_data == SPACE_BYTE) begin
            state_d = ST_LEN;
          end else begin
            err_set   = 1'b1;
            err_cause = ERR_BAD_SPACE;
          end
        end
        ST_LEN: begin
          if (byte_data != 8'd0 && byte_data <= MAX_LEN) begin
            len_d   = byte_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            err_set   = 1'b1;
            err_cause = ERR_BAD_LEN;
          end
        end
        ST_PAYLOAD: begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (8'(idx_q) == len_q - 8'd1) state_d = ST_EOF1;
        end
        ST_EOF1, ST_EOF2: begin
          if (byte_data != EOF_BYTE) begin
            err_set   = 1'b1;
            err_cause = ERR_BAD_EOF;
          end else begin
            state_d = (state_q == ST_EOF1) ? ST_EOF2 : ST_HOLD;
          end
        end
        default: ;
      endcase
    end else if (timeout) begin
      err_set   = 1'b1;
      err_cause = ERR_TIMEOUT;
    end
    if (err_set && state_q != ST_HOLD) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ferr_q  <= err_set;
      if (err_set) code_q <= err_cause;
    end
  end

  serial_frame_buffer #(
    .DEPTH (MAX_PAYLOAD_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (idx_q),
    .wr_data (byte_data),
    .rd_addr (rd_addr),
    .rd_len  (len_q),
    .rd_data (rd_data)
  );

  assign frame_valid = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_HOLD);
  assign payload_len = len_q;
  assign frame_error = ferr_q;
  assign error_code  = code_q;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Bench for serial_frame_decoder: position-based frame model,
// per-cycle compare, directed literal checks and random traffic.
module tb_serial_frame_decoder;

  localparam int MAXL  = 16;
  localparam int TICKS = 50000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_valid = 1'b0;
  logic       byte_err = 1'b0;
  logic       frame_ack = 1'b0;
  logic [3:0] rd_addr = '0;
  logic       frame_valid;
  logic [7:0] payload_len;
  logic [7:0] rd_data;
  logic       busy;
  logic       frame_error;
  logic [2:0] error_code;

  int total = 0;
  int bad = 0;

  serial_frame_decoder #(
    .MAX_PAYLOAD_LEN    (MAXL),
    .BYTE_TIMEOUT_TICKS (TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_err    (byte_err),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .payload_len (payload_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .frame_error (frame_error),
    .error_code  (error_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: pos counts bytes accepted into the current frame
  int         pos = 0;
  int         len = 0;
  int         gap = 0;
  bit         held = 0;
  bit         m_ferr = 0;
  int         m_code = 0;
  int         m_rd = 0;
  int         mc = 0;
  logic [7:0] pbuf [MAXL];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; len = 0; gap = 0; held = 0;
      m_ferr = 0; m_code = 0; m_rd = 0;
    end else begin
      mc = 0;
      m_rd = (int'(rd_addr) < len) ? int'(pbuf[rd_addr]) : 0;
      if (held) begin
        if (byte_valid) mc = 6;
        if (frame_ack) held = 0;
        pos = 0; gap = 0;
      end else if (byte_valid) begin
        gap = 0;
        if (pos == 0) begin
          if (!byte_err && byte_data == 8'hFF) pos = 1;
        end else if (byte_err) mc = 4;
        else if (pos == 1) pos = (byte_data == 8'hFF) ? 2 : 0;
        else if (pos == 2) begin
          if (byte_data == 8'h00) pos = 3; else mc = 1;
        end else if (pos == 3) begin
          if (byte_data >= 1 && byte_data <= MAXL) begin
            len = int'(byte_data); pos = 4;
          end else mc = 2;
        end else if (pos < 4 + len) begin
          pbuf[pos-4] = byte_data; pos++;
        end else if (byte_data != 8'hEE) mc = 3;
        else if (pos == 4 + len) pos++;
        else held = 1;
      end else if (pos > 0) begin
        gap++;
        if (gap == TICKS) mc = 5;
      end
      m_ferr = (mc != 0);
      if (mc != 0) begin
        m_code = mc;
        if (!held) begin pos = 0; gap = 0; end
      end
    end
  end

  always @(negedge clk) begin
    chk("frame_valid", frame_valid, held);
    chk("busy", busy, held);
    chk("frame_error", frame_error, m_ferr);
    chk("error_code", error_code, m_code);
    chk("payload_len", payload_len, len);
    if (held || len == 0) chk("rd_data", rd_data, m_rd);
  end

  task automatic send(input logic [7:0] d, input bit e);
    byte_data = d; byte_valid = 1'b1; byte_err = e;
    @(negedge clk);
    byte_valid = 1'b0; byte_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_rand(input int n);
    repeat (n) begin rd_addr = 4'($urandom); @(negedge clk); end
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) send(w[8*(n-1-i) +: 8], 1'b0);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic good(input int n);
    send_word(64'hFFFF00, 3);
    send(8'(n), 1'b0);
    for (int i = 0; i < n; i++) send(8'($urandom), 1'b0);
    send(8'hEE, 1'b0);
    send(8'hEE, 1'b0);
    chk("good_valid", frame_valid, 1);
    chk("good_len", payload_len, n);
    do_ack();
    chk("good_release", frame_valid, 0);
  endtask

  task automatic bad_seq(input logic [63:0] w, input int n,
                         input int code);
    send_word(w, n);
    chk("err_pulse", frame_error, 1);
    chk("err_code", error_code, code);
    idle(1);
    chk("err_single", frame_error, 0);
    good($urandom_range(1, MAXL));
  endtask

  int         r, n;
  logic [7:0] q[$];

  initial begin
    foreach (pbuf[i]) pbuf[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", frame_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", payload_len, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_ferr", frame_error, 0);
    chk("rst_code", error_code, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    send_word(64'hFFFF0002_0203EEEE, 8);
    chk("a_valid", frame_valid, 1);
    chk("a_busy", busy, 1);
    chk("a_len", payload_len, 2);
    rd_addr = 4'd0; @(negedge clk); chk("a_rd0", rd_data, 8'h02);
    rd_addr = 4'd1; @(negedge clk); chk("a_rd1", rd_data, 8'h03);
    rd_addr = 4'd2; @(negedge clk); chk("a_rd2", rd_data, 8'h00);
    do_ack();
    chk("a_rel", frame_valid, 0);
    chk("a_rel_busy", busy, 0);

    send_word(64'h5512FFFF_0001A5EE, 8);
    send(8'hEE, 1'b0);
    chk("b_valid", frame_valid, 1);
    chk("b_len", payload_len, 1);
    chk("b_code", error_code, 0);
    rd_addr = 4'd0; @(negedge clk); chk("b_rd0", rd_data, 8'hA5);
    do_ack();

    bad_seq(64'hFFFF01, 3, 1);
    bad_seq(64'hFFFF0000, 4, 2);
    bad_seq(64'hFFFF0011, 4, 2);
    bad_seq(64'hFFFF0001A5EE00, 7, 3);
    bad_seq(64'hFFFF0001A500, 6, 3);
    good(MAXL);

    send_word(64'hFFFF000311, 5);
    send(8'h22, 1'b1);
    chk("line_err", frame_error, 1);
    chk("line_code", error_code, 4);
    idle(2);
    chk("line_novalid", frame_valid, 0);
    good(3);

    send_word(64'hFFFF000411, 5);
    idle(TICKS - 1);
    chk("to_early", frame_error, 0);
    idle(1);
    chk("to_err", frame_error, 1);
    chk("to_code", error_code, 5);
    good(2);

    send_word(64'hFFFF0002_5AC3EEEE, 8);
    send(8'h77, 1'b0);
    chk("ov_err", frame_error, 1);
    chk("ov_code", error_code, 6);
    chk("ov_valid", frame_valid, 1);
    rd_addr = 4'd1; @(negedge clk); chk("ov_rd1", rd_data, 8'hC3);
    rd_addr = 4'd0; @(negedge clk); chk("ov_rd0", rd_data, 8'h5A);
    byte_data = 8'h12; byte_valid = 1'b1; frame_ack = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; frame_ack = 1'b0;
    chk("ova_err", frame_error, 1);
    chk("ova_code", error_code, 6);
    chk("ova_valid", frame_valid, 0);
    chk("ova_busy", busy, 0);

    send_word(64'hFFFF000511, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", frame_valid, 0);
    chk("mr_len", payload_len, 0);
    chk("mr_rd", rd_data, 0);
    chk("mr_code", error_code, 0);
    chk("mr_ferr", frame_error, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    good(3);

    for (int it = 0; it < 250; it++) begin
      q.delete();
      r = $urandom_range(0, 9);
      n = $urandom_range(1, MAXL);
      if (r == 2) repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
      q.push_back(8'hFF);
      q.push_back(8'hFF);
      q.push_back(8'h00);
      q.push_back((r == 1) ? 8'($urandom_range(0, 20)) : 8'(n));
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      q.push_back(8'hEE);
      q.push_back(8'hEE);
      if (r == 0) q[$urandom_range(0, q.size() - 1)] = 8'($urandom);
      foreach (q[i]) begin
        rd_addr = 4'($urandom);
        send(q[i], $urandom_range(0, 40) == 0);
        if ($urandom_range(0, 3) == 0) idle_rand($urandom_range(1, 3));
      end
      idle_rand($urandom_range(0, 2));
      if (held) begin
        if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'b0);
        idle_rand($urandom_range(0, 3));
        do_ack();
      end else if ($urandom_range(0, 4) == 0) begin
        do_ack();
      end
    end
    if (held) do_ack();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
